// File: rtl/oflow_iou_match_ctrl_if.sv
// oflow_iou_match_ctrl_if: sweep request, IoU calculator handshake and match result bundle
interface oflow_iou_match_ctrl_if #(
  parameter int HIST_IDX_LEN = 3,
  parameter int CNT_LEN = 4,
  parameter int IOU_LEN = 22
);
  logic start_match;
  logic [CNT_LEN-1:0] num_history;
  logic valid_iou;
  logic [IOU_LEN-1:0] iou;
  logic iou_start;
  logic [HIST_IDX_LEN-1:0] hist_idx;
  logic busy;
  logic match_valid;
  logic match_found;
  logic [HIST_IDX_LEN-1:0] match_idx;
  logic [IOU_LEN-1:0] match_cost;
  logic timeout_err;
  modport master (
    output start_match, num_history, valid_iou, iou,
    input iou_start, hist_idx, busy, match_valid, match_found, match_idx, match_cost, timeout_err
  );
  modport slave (
    input start_match, num_history, valid_iou, iou,
    output iou_start, hist_idx, busy, match_valid, match_found, match_idx, match_cost, timeout_err
  );
endinterface

// File: rtl/oflow_iou_match_ctrl.sv
// oflow_iou_match_ctrl: sweeps history bboxes through the IoU calculator and keeps the lowest cost
// OFLOW_IOU_THRESHOLD_EN adds an iou_threshold port that gates match_found.
module oflow_iou_match_ctrl #(
  parameter int NUM_HISTORY = 8,
  parameter int HIST_IDX_LEN = 3,
  parameter int CNT_LEN = 4,
  parameter int IOU_LEN = 22,
  parameter int TIMEOUT = 31
) (
  input logic clk,
  input logic reset_N,
`ifdef OFLOW_IOU_THRESHOLD_EN
  input logic [IOU_LEN-1:0] iou_threshold,
`endif
  oflow_iou_match_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {idle_st, issue_st, wait_st, done_st} state_t;
  state_t state_q, state_d;
  logic [CNT_LEN-1:0] num_q, num_d;
  logic [HIST_IDX_LEN-1:0] idx_q, idx_d, best_idx_q, best_idx_d, match_idx_q, match_idx_d;
  logic [IOU_LEN-1:0] best_cost_q, best_cost_d, match_cost_q, match_cost_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic any_valid_q, any_valid_d, tmo_err_q, tmo_err_d, found_q, found_d;
  logic last, expire, found;
`ifdef OFLOW_IOU_THRESHOLD_EN
  logic [IOU_LEN-1:0] thr_q, thr_d;
`endif
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    idx_d = idx_q;
    best_idx_d = best_idx_q;
    best_cost_d = best_cost_q;
    any_valid_d = any_valid_q;
    tmo_err_d = tmo_err_q;
    cnt_d = cnt_q;
    found_d = found_q;
    match_idx_d = match_idx_q;
    match_cost_d = match_cost_q;
`ifdef OFLOW_IOU_THRESHOLD_EN
    thr_d = thr_q;
`endif
    last = {1'b0, idx_q} == num_q - CNT_LEN'(1);
    expire = cnt_q == TW'(TIMEOUT - 1);
    case (state_q)
      idle_st: if (bus.start_match) begin
        num_d = bus.num_history > CNT_LEN'(NUM_HISTORY) ? CNT_LEN'(NUM_HISTORY) : bus.num_history;
        idx_d = '0;
        best_idx_d = '0;
        best_cost_d = '1;
        any_valid_d = 1'b0;
        tmo_err_d = 1'b0;
`ifdef OFLOW_IOU_THRESHOLD_EN
        thr_d = iou_threshold;
`endif
        state_d = bus.num_history == '0 ? done_st : issue_st;
      end
      issue_st: begin
        cnt_d = '0;
        state_d = wait_st;
      end
      wait_st: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.valid_iou) begin
          any_valid_d = 1'b1;
          if (bus.iou < best_cost_q) begin
            best_cost_d = bus.iou;
            best_idx_d = idx_q;
          end
        end else if (expire) tmo_err_d = 1'b1;
        if (bus.valid_iou || expire) begin
          state_d = last ? done_st : issue_st;
          idx_d = last ? idx_q : idx_q + 1'b1;
        end
      end
      default: state_d = idle_st;
    endcase
`ifdef OFLOW_IOU_THRESHOLD_EN
    found = any_valid_d && best_cost_d <= thr_d;
`else
    found = any_valid_d;
`endif
    // Result is captured on entry to done_st so it is stable while match_valid is high.
    if (state_d == done_st && state_q != done_st) begin
      found_d = found;
      match_idx_d = found ? best_idx_d : '0;
      match_cost_d = found ? best_cost_d : '1;
    end
  end
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q <= idle_st;
      num_q <= '0;
      idx_q <= '0;
      best_idx_q <= '0;
      best_cost_q <= '1;
      any_valid_q <= 1'b0;
      tmo_err_q <= 1'b0;
      cnt_q <= '0;
      found_q <= 1'b0;
      match_idx_q <= '0;
      match_cost_q <= '0;
`ifdef OFLOW_IOU_THRESHOLD_EN
      thr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      idx_q <= idx_d;
      best_idx_q <= best_idx_d;
      best_cost_q <= best_cost_d;
      any_valid_q <= any_valid_d;
      tmo_err_q <= tmo_err_d;
      cnt_q <= cnt_d;
      found_q <= found_d;
      match_idx_q <= match_idx_d;
      match_cost_q <= match_cost_d;
`ifdef OFLOW_IOU_THRESHOLD_EN
      thr_q <= thr_d;
`endif
    end
  end
  assign bus.iou_start = state_q == issue_st;
  assign bus.hist_idx = idx_q;
  assign bus.busy = state_q != idle_st;
  assign bus.match_valid = state_q == done_st;
  assign bus.match_found = found_q;
  assign bus.match_idx = match_idx_q;
  assign bus.match_cost = match_cost_q;
  assign bus.timeout_err = tmo_err_q;
endmodule

// File: tb/tb_oflow_iou_match_ctrl.sv
// tb_oflow_iou_match_ctrl: emulates the IoU calculator and checks sweep results against a min-search model
module tb_oflow_iou_match_ctrl;
  logic clk = 1'b0;
  logic reset_N = 1'b0;
  always #5 clk = ~clk;
  oflow_iou_match_ctrl_if bus ();
`ifdef OFLOW_IOU_THRESHOLD_EN
  logic [21:0] thr = 22'h3FFFFF;
`endif
  oflow_iou_match_ctrl dut (
    .clk(clk),
    .reset_N(reset_N),
`ifdef OFLOW_IOU_THRESHOLD_EN
    .iou_threshold(thr),
`endif
    .bus(bus)
  );
  int total = 0, bad = 0;
  logic [21:0] cost[8];
  int lat[8];
  bit on[8];
  int r_starts, r_mv, r_cyc;
  logic [2:0] r_idx;
  logic [21:0] r_cost;
  logic r_found, r_terr;
  bit r_seq_ok;
  int issue_t[$];
  int e_idx, e_starts, e_cyc;
  logic [21:0] e_cost;
  bit e_found, e_terr;

  function automatic void model(input int n);
    int m = n > 8 ? 8 : n;
    bit any = 0;
    e_idx = 0; e_cost = 22'h3FFFFF; e_terr = 0; e_starts = m; e_cyc = 1;
    for (int i = 0; i < m; i++) begin
      e_cyc += on[i] ? lat[i] + 1 : 32;
      if (!on[i]) e_terr = 1;
      else begin
        any = 1;
        if (cost[i] < e_cost) begin e_cost = cost[i]; e_idx = i; end
      end
    end
    e_found = any;
`ifdef OFLOW_IOU_THRESHOLD_EN
    e_found = any && e_cost <= thr;
`endif
    if (!e_found) begin e_idx = 0; e_cost = 22'h3FFFFF; end
  endfunction

  function automatic void fill(input logic [21:0] c, input int l);
    for (int i = 0; i < 8; i++) begin cost[i] = c; lat[i] = l; on[i] = 1; end
  endfunction

  task automatic run_sweep(input int n, input int spur_start, input bit spur_valid);
    int due = -1, ci = 0, t = 0;
    r_starts = 0; r_mv = 0; r_cyc = -1; r_seq_ok = 1; issue_t.delete();
    @(negedge clk);
    bus.start_match = 1'b1;
    bus.num_history = 4'(n);
    while (t < 600) begin
      @(negedge clk);
      t++;
      bus.start_match = (t == spur_start);
      bus.valid_iou = 1'b0;
      if (bus.match_valid) begin
        r_mv++;
        if (r_cyc < 0) begin
          r_cyc = t; r_idx = bus.match_idx; r_cost = bus.match_cost;
          r_found = bus.match_found; r_terr = bus.timeout_err;
        end
      end
      if (bus.iou_start) begin
        if (bus.hist_idx !== 3'(r_starts)) r_seq_ok = 0;
        r_starts++;
        issue_t.push_back(t);
        ci = int'(bus.hist_idx);
        due = on[ci] ? t + lat[ci] : -1;
        if (spur_valid) begin bus.valid_iou = 1'b1; bus.iou = '0; end
      end
      if (t == due) begin bus.valid_iou = 1'b1; bus.iou = cost[ci]; due = -1; end
      if (r_cyc >= 0 && !bus.busy) break;
    end
    bus.start_match = 1'b0;
    bus.valid_iou = 1'b0;
  endtask

  task automatic test_reset();
    bit seen = 0;
    bus.start_match = 0; bus.num_history = 0; bus.valid_iou = 0; bus.iou = 0;
    repeat (3) @(negedge clk);
    total++; if ({bus.busy, bus.iou_start, bus.match_valid, bus.match_found, bus.timeout_err} !== 5'b0)
      begin bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.busy, bus.iou_start, bus.match_valid, bus.match_found, bus.timeout_err}); end
    total++; if ({bus.match_idx, bus.match_cost, bus.hist_idx} !== 28'h0)
      begin bad++; $display("FAIL reset_values got=%h exp=0", {bus.match_idx, bus.match_cost, bus.hist_idx}); end
    reset_N = 1'b1;
    repeat (100) begin @(negedge clk); if (bus.iou_start || bus.busy || bus.match_valid) seen = 1; end
    total++; if (seen !== 0) begin bad++; $display("FAIL idle_quiet got=%0d exp=0", seen); end
  endtask

  task automatic test_directed();
    int n;
    for (int k = 0; k < 7; k++) begin
      fill(22'h3FFFFF, 9);
      case (k)
        0: begin n = 3; cost[0] = 22'h200000; cost[1] = 22'h080000; cost[2] = 22'h100000; end
        1: begin n = 4; cost[0] = 5; cost[1] = 3; cost[2] = 3; cost[3] = 7; lat[2] = 2; end
        2: n = 0;
        3: begin n = 2; on[0] = 0; cost[1] = 22'h000010; end
        4: begin n = 3; on[0] = 0; on[1] = 0; on[2] = 0; end
        5: begin n = 2; lat[0] = 31; cost[0] = 9; lat[1] = 1; cost[1] = 8; end
        default: begin n = 12; for (int i = 0; i < 8; i++) cost[i] = 22'(50 - i); lat[7] = 4; end
      endcase
      run_sweep(n, -1, 0);
      model(n);
      total++; if (r_mv !== 1) begin bad++; $display("FAIL dir%0d mv_count got=%0d exp=1", k, r_mv); end
      total++; if (r_cyc !== e_cyc) begin bad++; $display("FAIL dir%0d mv_cycle got=%0d exp=%0d", k, r_cyc, e_cyc); end
      total++; if (r_starts !== e_starts || r_seq_ok !== 1) begin bad++; $display("FAIL dir%0d starts got=%0d/%0d exp=%0d/1", k, r_starts, r_seq_ok, e_starts); end
      total++; if (r_idx !== 3'(e_idx)) begin bad++; $display("FAIL dir%0d idx got=%0d exp=%0d", k, r_idx, e_idx); end
      total++; if (r_cost !== e_cost) begin bad++; $display("FAIL dir%0d cost got=%h exp=%h", k, r_cost, e_cost); end
      total++; if (r_found !== e_found) begin bad++; $display("FAIL dir%0d found got=%0d exp=%0d", k, r_found, e_found); end
      total++; if (r_terr !== e_terr) begin bad++; $display("FAIL dir%0d terr got=%0d exp=%0d", k, r_terr, e_terr); end
      if (k == 3 || k == 5) begin
        total++; if (issue_t.size() != 2 || issue_t[1] - issue_t[0] != 32)
          begin bad++; $display("FAIL dir%0d issue_gap got=%0d exp=32", k, issue_t.size() == 2 ? issue_t[1] - issue_t[0] : -1); end
      end
    end
    total++; if (bus.match_idx !== 3'd7 || bus.match_cost !== 22'd43)
      begin bad++; $display("FAIL hold_result got=%0d/%h exp=7/2b", bus.match_idx, bus.match_cost); end
  endtask

  task automatic test_robust();
    fill(22'h3FFFFF, 9);
    cost[0] = 22'h200000; cost[1] = 22'h080000; cost[2] = 22'h100000;
    run_sweep(3, 5, 1);
    model(3);
    total++; if (r_mv !== 1 || r_cyc !== e_cyc) begin bad++; $display("FAIL robust_timing got=%0d@%0d exp=1@%0d", r_mv, r_cyc, e_cyc); end
    total++; if (r_starts !== 3) begin bad++; $display("FAIL robust_starts got=%0d exp=3", r_starts); end
    total++; if (r_idx !== 3'(e_idx) || r_cost !== e_cost || r_found !== e_found)
      begin bad++; $display("FAIL robust_result got=%0d/%h/%0d exp=%0d/%h/%0d", r_idx, r_cost, r_found, e_idx, e_cost, e_found); end
  endtask

  task automatic test_reset_mid();
    int mv = 0;
    fill(22'd5, 9);
    @(negedge clk); bus.start_match = 1'b1; bus.num_history = 4'd4;
    @(negedge clk); bus.start_match = 1'b0;
    repeat (15) @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0d exp=1", bus.busy); end
    reset_N = 1'b0;
    #1;
    total++; if ({bus.busy, bus.iou_start, bus.match_valid, bus.match_found, bus.timeout_err, bus.match_idx, bus.match_cost, bus.hist_idx} !== 33'h0)
      begin bad++; $display("FAIL mid_reset_outputs got=%h exp=0", {bus.busy, bus.match_found, bus.match_idx, bus.match_cost, bus.hist_idx}); end
    repeat (3) @(negedge clk);
    reset_N = 1'b1;
    repeat (60) begin @(negedge clk); if (bus.match_valid || bus.iou_start || bus.busy) mv++; end
    total++; if (mv !== 0) begin bad++; $display("FAIL mid_no_result got=%0d exp=0", mv); end
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(0, 10);
      for (int i = 0; i < 8; i++) begin
        cost[i] = $urandom_range(0, 2) == 0 ? 22'($urandom_range(0, 3)) : 22'($urandom_range(0, 22'h3FFFFF));
        lat[i] = $urandom_range(1, 31);
        on[i] = $urandom_range(0, 7) != 0;
      end
      run_sweep(n, $urandom_range(0, 1) ? 3 : -1, 0);
      model(n);
      total++; if (r_mv !== 1 || r_cyc !== e_cyc) begin bad++; $display("FAIL rnd%0d timing got=%0d@%0d exp=1@%0d", k, r_mv, r_cyc, e_cyc); end
      total++; if (r_starts !== e_starts || r_seq_ok !== 1) begin bad++; $display("FAIL rnd%0d starts got=%0d exp=%0d", k, r_starts, e_starts); end
      total++; if (r_idx !== 3'(e_idx) || r_cost !== e_cost)
        begin bad++; $display("FAIL rnd%0d best got=%0d/%h exp=%0d/%h", k, r_idx, r_cost, e_idx, e_cost); end
      total++; if (r_found !== e_found || r_terr !== e_terr)
        begin bad++; $display("FAIL rnd%0d flags got=%0d/%0d exp=%0d/%0d", k, r_found, r_terr, e_found, e_terr); end
    end
  endtask

`ifdef OFLOW_IOU_THRESHOLD_EN
  task automatic test_threshold();
    thr = 22'h100000;
    for (int k = 0; k < 2; k++) begin
      fill(22'h300000, 4);
      cost[1] = k == 0 ? 22'h0FFFFF : 22'h100001;
      run_sweep(2, -1, 0);
      total++; if (r_found !== (k == 0)) begin bad++; $display("FAIL thr%0d found got=%0d exp=%0d", k, r_found, k == 0); end
      total++; if (r_idx !== (k == 0 ? 3'd1 : 3'd0) || r_cost !== (k == 0 ? 22'h0FFFFF : 22'h3FFFFF))
        begin bad++; $display("FAIL thr%0d result got=%0d/%h", k, r_idx, r_cost); end
    end
    thr = 22'h3FFFFF;
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_robust();
    test_reset_mid();
    test_random();
`ifdef OFLOW_IOU_THRESHOLD_EN
    test_threshold();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
